shared_adder_arbiter: RTL and testbench
=======================================

Name: shared_adder_arbiter

Overview:
- Shares one DATAW-bit add/subtract unit between NREQ requesters, e.g. the sequential add states of several generated HLSM datapaths.
- Each requester raises a level request with its operands.
- The arbiter grants round-robin, captures the operands, runs the shared unit for LAT cycles, and returns the result with a one-cycle acknowledge.
- Gives resource-constrained sharing of the adder instead of one adder per HLSM state.

Parameters:
NREQ, 4, number of requesters (2..8)
DATAW, 33, operand/result width
LAT, 1, shared unit latency in cycles (>=1)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  synchronous active-high reset
req  input  NREQ  level request, bit k = requester k
sub  input  NREQ  op select per requester: 0 = a+b, 1 = a-b
op_a  input  NREQ*DATAW  operand A, requester k at bits [k*DATAW +: DATAW]
op_b  input  NREQ*DATAW  operand B, same packing
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-hot completion pulse, registered
result  output  DATAW  shared result, registered
carry  output  1  carry-out (add) or not-borrow (sub), registered
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset on a Clk edge with Rst=1:
  - gnt, ack, result, carry and busy go to 0.
  - State goes to IDLE, round-robin pointer ptr to 0, latency counter to 0.
  - Rst overrides every other event.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req != 0, the winner is the first set bit searching ptr, ptr+1, ... modulo NREQ.
  - On the edge: gnt <= onehot(winner), latch op_a/op_b/sub of the winner, cnt <= LAT-1, go to BUSY.
  - If req == 0, stay in IDLE.
- BUSY:
  - gnt is held.
  - If cnt == 0: on the edge, result <= latched a ± b modulo 2^DATAW, carry <= bit DATAW of the (DATAW+1)-bit computation (sub = a + ~b + 1), ack <= gnt, go to RESP.
  - Otherwise cnt decrements.
- RESP:
  - ack is high for exactly this cycle; gnt is still held.
  - On the edge: gnt <= 0, ack <= 0, ptr <= (winner+1) mod NREQ, go to IDLE.
- Timing:
  - Request to ack latency from the first IDLE cycle with req visible is LAT+1 cycles.
  - Transaction period is LAT+2 cycles.
- Requester rules:
  - A requester holds req until it samples ack=1, and deasserts req on that same edge.
  - The following IDLE cycle therefore never re-grants it spuriously.
- Operands and the sub select are sampled only on the grant edge. Later changes on op_a/op_b/sub, or dropping req while granted, do not affect the transaction; ack is still pulsed.
- result and carry hold their value until the next RESP entry. They are never cleared between transactions except by Rst.
- Fairness: simultaneous requests are served in rotating order. A continuously requesting port waits at most NREQ-1 transactions.
- At most one gnt bit and one ack bit are ever set, and ack is always a subset of gnt.
- Reset mid-transaction: the transaction is discarded with no ack pulse. After reset the next grant starts from ptr=0.

Test Plan:
- Reset then idle: Rst high 2 cycles, req=0 for 10 cycles -> gnt=0, ack=0, result=0, busy=0 throughout.
- Single add, LAT=1: req=0001, a0=5, b0=7, sub0=0 -> gnt=0001 on cycles 1-2, ack=0001 on cycle 2 only, result=12, carry=0.
- Overflow and subtract (DATAW=33):
  - a=0x1FFFFFFFF, b=1, add -> result=0, carry=1.
  - a=3, b=5, sub -> result=0x1FFFFFFFE, carry=0.
- Round-robin: req=1111 held, each port dropping req on its ack -> grant order 0,1,2,3. With req0 re-asserted immediately after its ack, order continues 0 after 3, and no port is granted twice before the others.
- Operand stability and LAT=3: change a0 and drop req0 during BUSY -> result uses the grant-edge values, ack arrives 4 cycles after the request is first seen, and result is unchanged afterwards until the next transaction.
- Reset mid-operation: Rst asserted during BUSY -> no ack, all outputs 0. Subsequent req=1010 grants port 1 first (ptr=0).

Source files
------------

// File: rtl/shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_adder_arbiter
// Brief    : Round-robin arbiter sharing one add/subtract unit among NREQ
//            requesters, with registered grant, ack pulse and result.
// Revision : 1.0 - initial release
// ============================================================================
module shared_adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int DATAW = 33,
    parameter int LAT   = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       sub,
    input  logic [NREQ*DATAW-1:0] op_a,
    input  logic [NREQ*DATAW-1:0] op_b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [DATAW-1:0]      result,
    output logic                  carry,
    output logic                  busy
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [c_PTR_W:0]   c_NREQ   = (c_PTR_W+1)'(NREQ);
    localparam logic [c_CNT_W-1:0] c_CNT_LD = c_CNT_W'(LAT - 1);
    localparam logic [NREQ-1:0]    c_ONE    = NREQ'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_win;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATAW-1:0]   r_a;
    logic [DATAW-1:0]   r_b;
    logic               r_sub;

    logic               w_found;
    logic [c_PTR_W-1:0] w_win;
    logic [c_PTR_W:0]   w_pick;
    logic [DATAW:0]     w_sum;

    logic [NREQ-1:0]    w_gnt_nxt;
    logic [NREQ-1:0]    w_ack_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic               w_latch;
    logic               w_res_load;

    // First set request bit starting at p and wrapping modulo NREQ.
    function automatic logic [c_PTR_W:0] f_pick(input logic [NREQ-1:0] r,
                                                input logic [c_PTR_W-1:0] p);
        logic [c_PTR_W:0]   v;
        logic [c_PTR_W-1:0] k;
        logic               found;
        logic [c_PTR_W-1:0] win;
        found = 1'b0;
        win   = p;
        for (int i = 0; i < NREQ; i++) begin
            v = {1'b0, p} + (c_PTR_W+1)'(i);
            if (v >= c_NREQ) v = v - c_NREQ;
            k = v[c_PTR_W-1:0];
            if (!found && r[k]) begin
                found = 1'b1;
                win   = k;
            end
        end
        return {found, win};
    endfunction

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        logic [c_PTR_W:0] v;
        v = {1'b0, p} + (c_PTR_W+1)'(1);
        if (v >= c_NREQ) v = v - c_NREQ;
        return v[c_PTR_W-1:0];
    endfunction

    assign w_pick  = f_pick(req, r_ptr);
    assign w_found = w_pick[c_PTR_W];
    assign w_win   = w_pick[c_PTR_W-1:0];

    // Subtraction is a + ~b + 1, so the top bit is the not-borrow flag.
    assign w_sum = {1'b0, r_a} + {1'b0, (r_sub ? ~r_b : r_b)} + {{DATAW{1'b0}}, r_sub};

    assign busy = (r_state != c_IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_win   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            gnt     <= '0;
            ack     <= '0;
            result  <= '0;
            carry   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            gnt     <= w_gnt_nxt;
            ack     <= w_ack_nxt;
            if (w_latch) begin
                r_win <= w_win;
                r_a   <= op_a[w_win*DATAW +: DATAW];
                r_b   <= op_b[w_win*DATAW +: DATAW];
                r_sub <= sub[w_win];
            end
            if (w_res_load) begin
                result <= w_sum[DATAW-1:0];
                carry  <= w_sum[DATAW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found) w_state_nxt = c_BUSY;
            c_BUSY:  if (r_cnt == '0) w_state_nxt = c_RESP;
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt  = gnt;
        w_ack_nxt  = '0;
        w_cnt_nxt  = r_cnt;
        w_ptr_nxt  = r_ptr;
        w_latch    = 1'b0;
        w_res_load = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt = c_ONE << w_win;
                    w_cnt_nxt = c_CNT_LD;
                    w_latch   = 1'b1;
                end
            end
            c_BUSY: begin
                if (r_cnt == '0) begin
                    w_res_load = 1'b1;
                    w_ack_nxt  = gnt;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
            end
            c_RESP: begin
                w_gnt_nxt = '0;
                w_ptr_nxt = f_next(r_win);
            end
            default: begin
                w_gnt_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_shared_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_adder_arbiter
// Brief    : Directed self-checking bench; one instance with LAT=1, one LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int DATAW = 33;

    logic                  Clk = 1'b0;
    logic                  Rst;

    logic [NREQ-1:0]       req1, sub1, gnt1, ack1;
    logic [NREQ*DATAW-1:0] a1, b1;
    logic [DATAW-1:0]      res1;
    logic                  carry1, busy1;

    logic [NREQ-1:0]       req3, sub3, gnt3, ack3;
    logic [NREQ*DATAW-1:0] a3, b3;
    logic [DATAW-1:0]      res3;
    logic                  carry3, busy3;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    shared_adder_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .LAT(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .req(req1), .sub(sub1), .op_a(a1), .op_b(b1),
        .gnt(gnt1), .ack(ack1), .result(res1), .carry(carry1), .busy(busy1)
    );

    shared_adder_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .LAT(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst), .req(req3), .sub(sub3), .op_a(a3), .op_b(b3),
        .gnt(gnt3), .ack(ack3), .result(res3), .carry(carry3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set1(input int p, input logic [DATAW-1:0] a, input logic [DATAW-1:0] b,
                        input logic s);
        a1[p*DATAW +: DATAW] = a;
        b1[p*DATAW +: DATAW] = b;
        sub1[p]              = s;
    endtask

    task automatic set3(input int p, input logic [DATAW-1:0] a, input logic [DATAW-1:0] b,
                        input logic s);
        a3[p*DATAW +: DATAW] = a;
        b3[p*DATAW +: DATAW] = b;
        sub3[p]              = s;
    endtask

    // One lone-requester transaction on the LAT=1 instance.
    task automatic txn1(input string tag, input int p, input logic [DATAW-1:0] a,
                        input logic [DATAW-1:0] b, input logic s,
                        input logic [DATAW-1:0] er, input logic ec);
        set1(p, a, b, s);
        req1    = '0;
        req1[p] = 1'b1;
        tick();
        check({tag, "_gnt"}, 64'(gnt1), 64'd1 << p);
        check({tag, "_ack_early"}, 64'(ack1), 64'd0);
        check({tag, "_busy"}, 64'(busy1), 64'd1);
        tick();
        check({tag, "_ack"}, 64'(ack1), 64'd1 << p);
        check({tag, "_gnt_resp"}, 64'(gnt1), 64'd1 << p);
        check({tag, "_result"}, 64'(res1), 64'(er));
        check({tag, "_carry"}, 64'(carry1), 64'(ec));
        req1 = '0;
        tick();
        check({tag, "_gnt_clr"}, 64'(gnt1), 64'd0);
        check({tag, "_ack_clr"}, 64'(ack1), 64'd0);
        check({tag, "_idle"}, 64'(busy1), 64'd0);
        check({tag, "_hold"}, 64'(res1), 64'(er));
    endtask

    initial begin
        Rst  = 1'b1;
        req1 = '0; sub1 = '0; a1 = '0; b1 = '0;
        req3 = '0; sub3 = '0; a3 = '0; b3 = '0;
        tick();
        tick();
        Rst = 1'b0;
        check("rst_gnt", 64'(gnt1), 64'd0);
        check("rst_ack", 64'(ack1), 64'd0);
        check("rst_result", 64'(res1), 64'd0);
        check("rst_carry", 64'(carry1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_gnt", 64'(gnt1), 64'd0);
            check("idle_ack", 64'(ack1), 64'd0);
            check("idle_result", 64'(res1), 64'd0);
            check("idle_busy", 64'(busy1), 64'd0);
            check("idle_busy3", 64'(busy3), 64'd0);
        end

        txn1("add", 0, 33'd5, 33'd7, 1'b0, 33'd12, 1'b0);
        txn1("ovf", 0, 33'h1_FFFF_FFFF, 33'd1, 1'b0, 33'd0, 1'b1);
        txn1("sub", 3, 33'd3, 33'd5, 1'b1, 33'h1_FFFF_FFFE, 1'b0);

        // Pointer is back at 0; all four request, port 0 re-requests once.
        for (int k = 0; k < NREQ; k++) set1(k, 33'(10 * k + 1), 33'(k), 1'b0);
        req1 = 4'hF;
        for (int s = 0; s < 5; s++) begin
            int p;
            p = s % NREQ;
            tick();
            check("rr_gnt", 64'(gnt1), 64'd1 << p);
            tick();
            check("rr_ack", 64'(ack1), 64'd1 << p);
            check("rr_result", 64'(res1), 64'(11 * p + 1));
            req1[p] = 1'b0;
            tick();
            check("rr_ack_clr", 64'(ack1), 64'd0);
            if (s == 0) req1[0] = 1'b1;
        end
        tick();
        check("rr_done_busy", 64'(busy1), 64'd0);
        check("rr_done_gnt", 64'(gnt1), 64'd0);

        // LAT=3: operands and req change after the grant edge.
        set3(0, 33'd100, 33'd30, 1'b1);
        req3 = 4'b0001;
        tick();
        check("lat3_gnt", 64'(gnt3), 64'd1);
        check("lat3_ack0", 64'(ack3), 64'd0);
        set3(0, 33'd999, 33'd30, 1'b0);
        req3 = '0;
        tick();
        check("lat3_ack1", 64'(ack3), 64'd0);
        check("lat3_gnt1", 64'(gnt3), 64'd1);
        check("lat3_busy1", 64'(busy3), 64'd1);
        tick();
        check("lat3_ack2", 64'(ack3), 64'd0);
        check("lat3_gnt2", 64'(gnt3), 64'd1);
        tick();
        check("lat3_ack", 64'(ack3), 64'd1);
        check("lat3_result", 64'(res3), 64'd70);
        check("lat3_carry", 64'(carry3), 64'd1);
        tick();
        check("lat3_ack_clr", 64'(ack3), 64'd0);
        check("lat3_gnt_clr", 64'(gnt3), 64'd0);
        tick();
        tick();
        tick();
        check("lat3_hold", 64'(res3), 64'd70);
        check("lat3_idle", 64'(busy3), 64'd0);

        // Port 2 full transaction moves the pointer to 3.
        set3(2, 33'h1_0000_0000, 33'h1_0000_0000, 1'b0);
        req3 = 4'b0100;
        tick();
        check("p2_gnt", 64'(gnt3), 64'd4);
        tick();
        tick();
        tick();
        check("p2_ack", 64'(ack3), 64'd4);
        check("p2_result", 64'(res3), 64'd0);
        check("p2_carry", 64'(carry3), 64'd1);
        req3 = '0;
        tick();

        // Reset in BUSY discards the transaction and clears the pointer.
        set3(2, 33'd7, 33'd8, 1'b0);
        req3 = 4'b0100;
        tick();
        check("mid_gnt", 64'(gnt3), 64'd4);
        tick();
        Rst = 1'b1;
        tick();
        Rst  = 1'b0;
        req3 = '0;
        check("mid_rst_gnt", 64'(gnt3), 64'd0);
        check("mid_rst_ack", 64'(ack3), 64'd0);
        check("mid_rst_result", 64'(res3), 64'd0);
        check("mid_rst_carry", 64'(carry3), 64'd0);
        check("mid_rst_busy", 64'(busy3), 64'd0);
        check("mid_rst_result1", 64'(res1), 64'd0);
        set3(1, 33'd2, 33'd3, 1'b0);
        set3(3, 33'd50, 33'd1, 1'b0);
        req3 = 4'b1010;
        tick();
        check("post_gnt", 64'(gnt3), 64'd2);
        check("post_ack0", 64'(ack3), 64'd0);
        tick();
        check("post_ack1", 64'(ack3), 64'd0);
        tick();
        check("post_ack2", 64'(ack3), 64'd0);
        tick();
        check("post_ack", 64'(ack3), 64'd2);
        check("post_result", 64'(res3), 64'd5);
        req3 = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
